decoder_seq_n: RTL

//  Registered, parametrised N-to-2^N one-hot decoder with two modes.

---
 rtl/decoder_seq_n_if.sv | 35 +++
 rtl/decoder_seq_n.sv | 101 ++++++++++
 2 files changed

// File: rtl/decoder_seq_n_if.sv
// decoder_seq_n_if: index handshake and decoded-output bundle
// master drives the index, slave is the decoder
interface decoder_seq_n_if #(
  parameter int N = 3
);
  localparam int W = 1 << N;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic [W-1:0] out;
  logic         out_valid;
  logic [N-1:0] idx;
  logic         wrap;

  modport master (
    output in_valid,
    output in,
    input  in_ready,
    input  out,
    input  out_valid,
    input  idx,
    input  wrap
  );

  modport slave (
    input  in_valid,
    input  in,
    output in_ready,
    output out,
    output out_valid,
    output idx,
    output wrap
  );
endinterface

// File: rtl/decoder_seq_n.sv
// decoder_seq_n: registered N-to-2^N one-hot decoder
// DIRECT decodes a handshaked index, SCAN walks the bits
module decoder_seq_n #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  decoder_seq_n_if.slave     bus
);
  localparam int W = 1 << N;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t             state_q;
  state_t             state_n;
  logic [W-1:0]       out_q;
  logic [W-1:0]       out_n;
  logic [N-1:0]       idx_q;
  logic [N-1:0]       idx_n;
  logic               ov_q;
  logic               ov_n;
  logic               wrap_q;
  logic               wrap_n;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_n;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // next state and next output values
  always_comb begin
    state_n = state_q;
    out_n   = out_q;
    idx_n   = idx_q;
    ov_n    = ov_q;
    wrap_n  = 1'b0;
    cnt_n   = cnt_q;
    if (!en) begin
      state_n = IDLE;
      out_n   = '0;
      ov_n    = 1'b0;
    end else if (mode) begin
      state_n = SCAN;
      if (state_q != SCAN) begin
        out_n = ONE;
        idx_n = '0;
        ov_n  = 1'b1;
        cnt_n = dwell;
      end else if (cnt_q == '0) begin
        idx_n  = idx_q + N'(1);
        out_n  = ONE << idx_n;
        wrap_n = (idx_q == {N{1'b1}});
        cnt_n  = dwell;
      end else begin
        cnt_n = cnt_q - DWELL_W'(1);
      end
    end else begin
      state_n = DIRECT;
      if (state_q == DIRECT && bus.in_valid) begin
        out_n = ONE << bus.in;
        idx_n = bus.in;
        ov_n  = 1'b1;
      end
    end
  end

  // registered outputs and dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      idx_q  <= '0;
      ov_q   <= 1'b0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_n;
      idx_q  <= idx_n;
      ov_q   <= ov_n;
      wrap_q <= wrap_n;
      cnt_q  <= cnt_n;
    end
  end

  assign bus.in_ready  = (state_q == DIRECT);
  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.idx       = idx_q;
  assign bus.wrap      = wrap_q;
endmodule
